// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_n_fa.sv
// One-bit full adder built from two half-adder cells and an OR gate.
// The half adder is kept as its own cell so the structure is explicit.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum and carry of two bits.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule : half_adder

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  // At most one of the two half-adder carries can be set, so OR merges them.
  always_comb begin
    co = c1 | c2;
  end

endmodule : full_adder

// File: rtl/serial_adder_n.sv
// Bit-serial adder: one full adder processes one bit per clock, LSB first.
// Operands are captured on an accepted start; sum/cout are registered and
// only updated when the whole word is complete, so partial results never
// reach the outputs.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] msb_bit;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_d;

  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next result word: shift right and drop the new sum bit in at the MSB,
  // so after WIDTH steps the first (LSB) bit has arrived at bit 0.
  always_comb begin
    msb_bit            = '0;
    msb_bit[WIDTH-1]   = fa_s;
    res_d              = (res_q >> 1) | msb_bit;
    cnt_d              = cnt_q + CW'(1);
  end

  // Control FSM and datapath registers; outputs are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            res_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          res_q   <= res_d;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= fa_co;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_n

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 1..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 SHALL have port sum  output  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding 2 bits.
REQ-013 IDLE: start=1 SHALL capture a, b, cin into internal shift/carry registers, clear bit counter, go to RUN.
REQ-014 RUN: each cycle SHALL add the current LSB of A, B and the carry register, shift the sum bit into the result register MSB-first (LSB ends at bit 0), update carry, increment counter.
REQ-015 RUN SHALL last exactly WIDTH cycles, then go to DONE; counter width $clog2(WIDTH+1).
REQ-016 DONE: done=1 for exactly one cycle; sum and cout SHALL be valid from this cycle.
REQ-017 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL capture new operands and go to RUN (back-to-back).
REQ-018 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+WIDTH.
REQ-019 busy SHALL be 1 in RUN only; 0 in IDLE and DONE.
REQ-020 start while in RUN SHALL be ignored; operands and progress unaffected.
REQ-021 sum and cout SHALL hold their last completed value in IDLE until the next DONE; intermediate partial values SHALL NOT appear on sum/cout during RUN.
REQ-022 Changes on a, b, cin after capture SHALL NOT affect the result in progress.
REQ-023 WIDTH=1 SHALL complete with one RUN cycle; full-width overflow SHALL set cout only, no wrap into sum beyond mod 2^WIDTH.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, counter and internal registers 0.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done pulse for the aborted request.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 State encodings (IDLE=0, RUN=1, DONE=2) SHALL live in shared package serial_adder_pkg.
REQ-028 The per-bit add SHALL be a combinational sub-module full_adder (a, b, cin -> s, co), built from two half-adder cells plus OR; instantiated once.
REQ-029 No combinational path from start, a, b or cin to any output.

Verification
REQ-030 WIDTH=8: a=8'h00, b=8'h00, cin=0, start 1 cycle -> busy 8 cycles, done pulse, sum=8'h00, cout=0.
REQ-031 WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> done 9 cycles after start edge, sum=8'h00, cout=1.
REQ-032 WIDTH=8: a=8'hA5, b=8'h5A, cin=1, start re-pulsed at RUN cycle 3 with a=8'h01 -> re-pulse ignored, sum=8'h00, cout=1.
REQ-033 WIDTH=8: start with a=8'h3C, b=8'h0F, rst at RUN cycle 4 -> no done, all outputs 0; next start a=8'h3C, b=8'h0F -> sum=8'h4B, cout=0.
REQ-034 WIDTH=8: start held high across DONE -> second addition starts without IDLE cycle, done pulses 9 cycles apart.
REQ-035 WIDTH=1: all 8 (a,b,cin) combos -> {cout,sum} equals a+b+cin, done 2 cycles after each start edge.
